// File: rtl/core_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch unit, its FIFO and its memory interface import this package.
package core_fetch_unit_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  localparam int FIFO_DEPTH_DEFAULT = 2;

  typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [MEM_DATA_WIDTH-1:0] data_t;

  localparam data_t NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam addr_t RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_S_BOOT  = 2'd0,
    IF_S_RUN   = 2'd1,
    IF_S_DRAIN = 2'd2
  } if_state_e;

  // One buffered fetch result: the address it came from and the word returned.
  typedef struct packed {
    addr_t pc;
    data_t instr;
  } fetch_entry_t;

  function automatic addr_t align_word(addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/core_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
// The fetch unit uses the master side; the memory (or a bench model) the slave side.
interface core_fetch_unit_if;
  import core_fetch_unit_pkg::*;

  logic  imem_req_o;
  addr_t imem_addr_o;
  logic  imem_gnt_i;
  logic  imem_rvalid_i;
  data_t imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, instruction} pairs for decode.
// Flush has priority over push and pop; the head is visible combinationally.
module core_fetch_fifo
  import core_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = MEM_ADDR_WIDTH + MEM_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i & (count_q != FULL_COUNT);
    pop_ok   = pop_i & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/core_fetch_unit.sv
// Instruction fetch stage: credit-based imem requester feeding decode through a small FIFO.
// Redirects flush buffered words and drop responses that were already in flight.
module core_fetch_unit
  import core_fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC   = RESET_PC_DEFAULT,
  parameter int    FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter data_t NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  core_fetch_unit_if.master imem,
  input  logic              redirect_i,
  input  addr_t             redirect_pc_i,
  output logic              instr_valid_o,
  output data_t             instr_o,
  output addr_t             pc_o,
  input  logic              instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

  if_state_e state_q, state_d;
  addr_t     fetch_pc_q, fetch_pc_d;
  addr_t     resp_pc_q, resp_pc_d;
  addr_t     addr_q, addr_d;
  logic      req_q, req_d;
  cnt_t      outstanding_q, outstanding_d;
  cnt_t      discard_q, discard_d;

  logic         grant, rvalid, redirect_en, push, pop, flush;
  addr_t        redirect_target;
  cnt_t         fifo_count, fifo_count_next;
  logic         fifo_full, fifo_empty;
  fetch_entry_t wr_entry, head;
  logic [CW:0]  credit_sum;

  core_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A redirect throws away the word returning this cycle but still lets decode take the head.
  always_comb begin
    grant           = req_q & imem.imem_gnt_i;
    rvalid          = imem.imem_rvalid_i;
    redirect_en     = redirect_i & (state_q != IF_S_BOOT);
    redirect_target = align_word(redirect_pc_i);
    pop             = ~fifo_empty & instr_ready_i;
    push            = rvalid & (discard_q == '0) & ~redirect_en;
    flush           = redirect_en;
    wr_entry.pc     = resp_pc_q;
    wr_entry.instr  = imem.imem_rdata_i;
  end

  always_comb begin
    outstanding_d   = outstanding_q + cnt_t'(grant) - cnt_t'(rvalid);
    fifo_count_next = flush ? '0 : (fifo_count + cnt_t'(push) - cnt_t'(pop));

    discard_d = discard_q;
    if (redirect_en) begin
      discard_d = outstanding_d;
    end else if (rvalid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
    end

    state_d = state_q;
    unique case (state_q)
      IF_S_BOOT:  state_d = IF_S_RUN;
      IF_S_RUN:   if (redirect_en && (discard_d != '0)) state_d = IF_S_DRAIN;
      IF_S_DRAIN: if (discard_d == '0) state_d = IF_S_RUN;
      default:    state_d = IF_S_BOOT;
    endcase

    // Request is registered from next-cycle counts so it already reflects this cycle's traffic.
    credit_sum = {1'b0, outstanding_d} + {1'b0, fifo_count_next};
    req_d      = (state_d == IF_S_RUN) && (credit_sum < CREDIT_LIMIT);
    addr_d     = fetch_pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IF_S_BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      addr_q        <= RESET_PC;
      req_q         <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;

  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_o          = fifo_empty ? RESET_PC  : head.pc;

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) rvalid |-> (outstanding_q != '0));

  no_fifo_overflow: assert property (
    @(posedge clk) disable iff (rst) push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_core_fetch_unit.sv
// Randomized bench for core_fetch_unit: an in-order memory model plus a queue-level
// reference of what decode must see, checked every cycle, with directed literal scenarios.
module tb_core_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  core_fetch_unit_if imem_if();

  core_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_if),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  // Requests the memory has accepted; stale ones were overtaken by a redirect.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    logic        stale;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetched_t;

  mem_req_t    memq[$];
  fetched_t    fifoq[$];
  logic        booting;
  logic [31:0] m_fetch_pc;
  int          cyc = 0;

  int          gnt_pct, ready_pct, redir_permille, lat_min, lat_max;
  logic        force_redirect;
  logic [31:0] force_target;
  logic        seen;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_req();
    logic any_stale;
    any_stale = 1'b0;
    for (int i = 0; i < memq.size(); i++) begin
      if (memq[i].stale) any_stale = 1'b1;
    end
    return !booting && !any_stale && ((memq.size() + fifoq.size()) < DEPTH);
  endfunction

  task automatic idleInputs();
    imem_if.imem_gnt_i    = 1'b0;
    imem_if.imem_rvalid_i = 1'b0;
    imem_if.imem_rdata_i  = 32'h0;
    redirect_i            = 1'b0;
    redirect_pc_i         = 32'h0;
    instr_ready_i         = 1'b0;
  endtask

  task automatic resetModel();
    memq.delete();
    fifoq.delete();
    booting        = 1'b1;
    m_fetch_pc     = RST_PC;
    force_redirect = 1'b0;
  endtask

  task automatic checkOutput();
    logic exp_req;
    exp_req = model_req();
    chk("req", 32'(imem_if.imem_req_o), 32'(exp_req));
    if (exp_req) chk("addr", imem_if.imem_addr_o, m_fetch_pc);
    chk("valid", 32'(instr_valid_o), 32'(fifoq.size() != 0));
    if (fifoq.size() != 0) begin
      chk("instr", instr_o, fifoq[0].instr);
      chk("pc", pc_o, fifoq[0].pc);
    end else begin
      chk("nop", instr_o, NOP);
    end
  endtask

  // Drive one cycle's inputs and advance the reference to the state after the next edge.
  task automatic applyStimulus();
    logic        exp_req, g, rv, rd, rdy, live_redirect;
    logic [31:0] tgt;
    mem_req_t    h, e, tmp;
    fetched_t    f;
    exp_req = model_req();
    g   = int'($urandom_range(99)) < gnt_pct;
    rv  = (memq.size() != 0) && (memq[0].due <= cyc);
    rdy = int'($urandom_range(99)) < ready_pct;
    rd  = force_redirect || (int'($urandom_range(999)) < redir_permille);
    tgt = force_redirect ? force_target : $urandom;
    force_redirect = 1'b0;

    imem_if.imem_gnt_i    = g;
    imem_if.imem_rvalid_i = rv;
    imem_if.imem_rdata_i  = rv ? memq[0].data : $urandom;
    redirect_i            = rd;
    redirect_pc_i         = tgt;
    instr_ready_i         = rdy;

    live_redirect = rd && !booting;
    h = '0;
    if (rv) h = memq.pop_front();
    if ((fifoq.size() != 0) && rdy) void'(fifoq.pop_front());
    if (rv && !h.stale && !live_redirect) begin
      f.pc    = h.addr;
      f.instr = h.data;
      fifoq.push_back(f);
    end
    if (exp_req && g) begin
      e.addr  = m_fetch_pc;
      e.data  = $urandom;
      e.due   = cyc + int'($urandom_range(lat_max, lat_min));
      e.stale = 1'b0;
      memq.push_back(e);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (live_redirect) begin
      fifoq.delete();
      for (int i = 0; i < memq.size(); i++) begin
        tmp       = memq[i];
        tmp.stale = 1'b1;
        memq[i]   = tmp;
      end
      m_fetch_pc = {tgt[31:2], 2'b00};
    end
    booting = 1'b0;
    cyc++;
  endtask

  task automatic stepCycle();
    checkOutput();
    applyStimulus();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    resetModel();
    #1;
    chk("rst_req", 32'(imem_if.imem_req_o), 32'd0);
    chk("rst_addr", imem_if.imem_addr_o, RST_PC);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, RST_PC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setKnobs(input int g, input int r, input int rd, input int lmin, input int lmax);
    gnt_pct        = g;
    ready_pct      = r;
    redir_permille = rd;
    lat_min        = lmin;
    lat_max        = lmax;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    resetModel();
    setKnobs(100, 100, 0, 1, 1);

    // Streaming: req from cycle 1, first instruction visible in cycle 3.
    doReset();
    chk("t1_c0_req", 32'(imem_if.imem_req_o), 32'd0);
    stepCycle();
    chk("t1_c1_req", 32'(imem_if.imem_req_o), 32'd1);
    chk("t1_c1_addr", imem_if.imem_addr_o, 32'h0);
    stepCycle();
    chk("t1_c2_addr", imem_if.imem_addr_o, 32'h4);
    stepCycle();
    chk("t1_c3_valid", 32'(instr_valid_o), 32'd1);
    chk("t1_c3_pc", pc_o, 32'h0);
    stepCycle();
    chk("t1_c4_pc", pc_o, 32'h4);
    repeat (20) stepCycle();

    // Backpressure: two grants fill the credits, then pops resume requests.
    setKnobs(100, 0, 0, 1, 1);
    doReset();
    repeat (6) stepCycle();
    chk("t2_req_low", 32'(imem_if.imem_req_o), 32'd0);
    chk("t2_head_pc", pc_o, 32'h0);
    ready_pct = 100;
    stepCycle();
    chk("t2_second_pc", pc_o, 32'h4);
    chk("t2_req_back", 32'(imem_if.imem_req_o), 32'd1);
    repeat (10) stepCycle();

    // Redirect with two requests in flight: both responses dropped, restart at 0x100.
    setKnobs(100, 100, 0, 4, 4);
    doReset();
    repeat (3) stepCycle();
    chk("t3_credit_full", 32'(imem_if.imem_req_o), 32'd0);
    force_redirect = 1'b1;
    force_target   = 32'h0000_0103;
    stepCycle();
    chk("t3_addr", imem_if.imem_addr_o, 32'h100);
    chk("t3_drain_req", 32'(imem_if.imem_req_o), 32'd0);
    stepCycle();
    chk("t3_drain_req2", 32'(imem_if.imem_req_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (instr_valid_o) begin
        seen = 1'b1;
        chk("t3_first_pc", pc_o, 32'h100);
      end else begin
        stepCycle();
      end
    end
    if (!seen) chk("t3_deliver_timeout", 32'(instr_valid_o), 32'd1);
    repeat (10) stepCycle();

    // Redirect together with rvalid and a decode handshake.
    setKnobs(100, 100, 0, 1, 1);
    doReset();
    repeat (3) stepCycle();
    chk("t4_valid", 32'(instr_valid_o), 32'd1);
    force_redirect = 1'b1;
    force_target   = 32'h0000_0200;
    stepCycle();
    chk("t4_flushed", 32'(instr_valid_o), 32'd0);
    chk("t4_nop", instr_o, NOP);
    repeat (10) stepCycle();

    // Grant withheld: address and request must hold steady.
    setKnobs(0, 100, 0, 1, 2);
    doReset();
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_req", 32'(imem_if.imem_req_o), 32'd1);
      chk("t5_hold_addr", imem_if.imem_addr_o, 32'h0);
      stepCycle();
    end
    gnt_pct = 100;
    repeat (10) stepCycle();

    // Address wrap past the top of memory.
    setKnobs(0, 100, 0, 1, 1);
    doReset();
    stepCycle();
    force_redirect = 1'b1;
    force_target   = 32'hFFFF_FFFC;
    stepCycle();
    chk("t6_top_addr", imem_if.imem_addr_o, 32'hFFFF_FFFC);
    chk("t6_top_req", 32'(imem_if.imem_req_o), 32'd1);
    gnt_pct = 100;
    stepCycle();
    chk("t6_wrap_addr", imem_if.imem_addr_o, 32'h0);
    repeat (10) stepCycle();

    // Random traffic, with an asynchronous reset landing mid-burst.
    setKnobs(70, 60, 40, 1, 4);
    doReset();
    repeat (1500) stepCycle();
    #2 rst = 1'b1;
    idleInputs();
    #1;
    chk("t7_async_req", 32'(imem_if.imem_req_o), 32'd0);
    chk("t7_async_valid", 32'(instr_valid_o), 32'd0);
    chk("t7_async_instr", instr_o, NOP);
    @(negedge clk);
    doReset();
    repeat (1500) stepCycle();

    setKnobs(100, 100, 20, 1, 1);
    doReset();
    repeat (1000) stepCycle();

    setKnobs(40, 30, 80, 1, 3);
    doReset();
    repeat (1500) stepCycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
